// File: rtl/pulse_meas_sched.sv
// pulse_meas_sched: shares one pulse-period engine across CH_NUM inputs, scanning enabled channels in ascending order.
// Ports: i_clk/i_rst (sync, active-high); i_start + i_ch_mask begin a scan; i_pulse are the channel inputs;
//        o_busy/o_done give scan status; o_res_* with o_res_vld/i_res_rdy return one result per channel.
// Optional: define PMS_CONT_SCAN_EN to add i_stop and make the scan wrap around until stopped.
module pulse_meas_sched #(
    parameter int CH_NUM  = 4,
    parameter int CNT_W   = 16,
    parameter int AVG_N   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [CH_NUM-1:0]         i_ch_mask,
    input  logic [CH_NUM-1:0]         i_pulse,
`ifdef PMS_CONT_SCAN_EN
    input  logic                      i_stop,
`endif
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_res_vld,
    input  logic                      i_res_rdy,
    output logic [$clog2(CH_NUM)-1:0] o_res_ch,
    output logic [CNT_W-1:0]          o_res_period,
    output logic                      o_res_timeout
);
    localparam int CH_W  = $clog2(CH_NUM);
    localparam int SH    = $clog2(AVG_N);
    localparam int ACC_W = CNT_W + SH;
    localparam int EC_W  = SH + 1;
    localparam int GAP_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SELECT, ARM, MEAS, REPORT} state_t;

    state_t            r_state;
    logic [CH_NUM-1:0] r_mask;
    logic [CH_W-1:0]   r_ch;
    logic              r_sel;
    logic [1:0]        r_hist;
    logic [GAP_W-1:0]  r_gap;
    logic [ACC_W-1:0]  r_acc;
    logic [EC_W-1:0]   r_ecnt;
    logic              r_busy;
    logic              r_done;
    logic              r_vld;
    logic [CH_W-1:0]   r_res_ch;
    logic [CNT_W-1:0]  r_res_period;
    logic              r_to;

    logic              w_edge;
    logic              w_gap_to;
    logic              w_fin_to;
    logic              w_fin_ok;
    logic              w_end;
    logic              w_hi_vld;
    logic              w_lo_vld;
    logic [CH_W-1:0]   w_hi_ch;
    logic [CH_W-1:0]   w_lo_ch;
    logic [CH_NUM-1:0] w_lo_src;
    logic [ACC_W-1:0]  w_acc_nx;

    assign w_edge   = r_hist[0] & ~r_hist[1];
    assign w_gap_to = r_gap == GAP_W'(TIMEOUT - 1);
    assign w_acc_nx = r_acc + 1'b1;
    // In IDLE the lowest-bit search looks at the incoming mask; otherwise at the latched one (for wrap).
    assign w_lo_src = (r_state == IDLE) ? i_ch_mask : r_mask;
    // An all-ones accumulator cannot absorb this cycle's increment, so it is treated as overflow.
    assign w_fin_to = (r_state == ARM && !w_edge && w_gap_to) ||
                      (r_state == MEAS && ((&r_acc) || (!w_edge && w_gap_to)));
    assign w_fin_ok = r_state == MEAS && !(&r_acc) && w_edge && r_ecnt == EC_W'(AVG_N - 1);

    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_ch  = '0;
        w_lo_vld = 1'b0;
        w_lo_ch  = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (r_mask[i] && i > int'(r_ch)) begin
                w_hi_vld = 1'b1;
                w_hi_ch  = CH_W'(i);
            end
            if (w_lo_src[i]) begin
                w_lo_vld = 1'b1;
                w_lo_ch  = CH_W'(i);
            end
        end
    end

`ifdef PMS_CONT_SCAN_EN
    logic r_stop;
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state == IDLE)
            r_stop <= 1'b0;
        else
            r_stop <= r_stop | (r_busy & i_stop);
    end
    assign w_end = r_stop | i_stop;
`else
    assign w_end = ~w_hi_vld;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_mask       <= '0;
            r_ch         <= '0;
            r_sel        <= 1'b0;
            r_hist       <= '0;
            r_gap        <= '0;
            r_acc        <= '0;
            r_ecnt       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_vld        <= 1'b0;
            r_res_ch     <= '0;
            r_res_period <= '0;
            r_to         <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], i_pulse[r_ch]};
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_mask <= i_ch_mask;
                    r_ch   <= w_lo_ch;
                    r_sel  <= 1'b0;
                    r_busy <= w_lo_vld;
                    r_done <= ~w_lo_vld;
                    if (w_lo_vld)
                        r_state <= SELECT;
                end
                // Two cycles let both history bits refill from the new channel.
                SELECT: begin
                    r_sel <= 1'b1;
                    if (r_sel) begin
                        r_state <= ARM;
                        r_gap   <= '0;
                    end
                end
                ARM: if (w_edge) begin
                    r_state <= MEAS;
                    r_acc   <= '0;
                    r_ecnt  <= '0;
                    r_gap   <= '0;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
                MEAS: begin
                    r_acc <= w_acc_nx;
                    if (w_edge) begin
                        r_ecnt <= r_ecnt + 1'b1;
                        r_gap  <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                REPORT: if (i_res_rdy) begin
                    r_vld <= 1'b0;
                    if (w_end) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= SELECT;
                        r_sel   <= 1'b0;
                        r_ch    <= w_hi_vld ? w_hi_ch : w_lo_ch;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_fin_to || w_fin_ok) begin
                r_state      <= REPORT;
                r_vld        <= 1'b1;
                r_res_ch     <= r_ch;
                r_res_period <= w_fin_to ? '1 : w_acc_nx[ACC_W-1:SH];
                r_to         <= w_fin_to;
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_res_vld     = r_vld;
    assign o_res_ch      = r_res_ch;
    assign o_res_period  = r_res_period;
    assign o_res_timeout = r_to;
endmodule

// File: tb/tb_pulse_meas_sched.sv
// tb_pulse_meas_sched: randomized and directed checks of pulse_meas_sched against a result-queue model.
module tb_pulse_meas_sched;
    localparam int CH_NUM  = 4;
    localparam int CNT_W   = 16;
    localparam int AVG_N   = 4;
    localparam int TIMEOUT = 1000;
    localparam int CH_W    = $clog2(CH_NUM);
`ifdef PMS_CONT_SCAN_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] per;
        logic             to;
    } res_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, rdy = 1'b1, stop = 1'b0;
    logic [CH_NUM-1:0] mask = '0, pulse = '0;
    logic busy, done, vld, res_to;
    logic [CH_W-1:0] res_ch;
    logic [CNT_W-1:0] res_per;

    always #5 clk = ~clk;

    pulse_meas_sched #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .AVG_N(AVG_N), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_ch_mask(mask), .i_pulse(pulse),
`ifdef PMS_CONT_SCAN_EN
        .i_stop(stop),
`endif
        .o_busy(busy), .o_done(done), .o_res_vld(vld), .i_res_rdy(rdy),
        .o_res_ch(res_ch), .o_res_period(res_per), .o_res_timeout(res_to)
    );

    // Channel stimulus: dead 0 = periodic (period per, high for hi cycles), 1 = stuck low, 2 = stuck high.
    int per[CH_NUM], hi[CH_NUM], dead[CH_NUM], ph[CH_NUM];
    bit rnd = 1'b0;
    int vectors = 0, errors = 0, dones = 0;
    res_t q[$], got[$];
    logic [CH_NUM-1:0] m_mask = '0;
    bit e_busy = 1'b0, e_done = 1'b0, e_rst = 1'b0, hs_prev = 1'b0, stop_req = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic res_t exp_of(input int c);
        res_t r;
        r.ch  = CH_W'(c);
        r.per = (dead[c] != 0) ? '1 : CNT_W'(per[c]);
        r.to  = dead[c] != 0;
        return r;
    endfunction

    function automatic void fill();
        for (int c = 0; c < CH_NUM; c++)
            if (m_mask[c]) q.push_back(exp_of(c));
    endfunction

    // Compare then advance the model with the inputs the next rising edge will sample.
    always @(negedge clk) begin
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (done) dones++;
        if (e_rst) begin
            chk("rst_vld", vld, 0);
            chk("rst_ch", res_ch, 0);
            chk("rst_per", res_per, 0);
            chk("rst_to", res_to, 0);
        end
        if (hs_prev) chk("vld_fall", vld, 0);
        if (vld) begin
            if (q.size() == 0) chk("vld_unexpected", vld, 0);
            else begin
                chk("res_ch", res_ch, q[0].ch);
                chk("res_per", res_per, q[0].per);
                chk("res_to", res_to, q[0].to);
            end
        end
        e_done = 1'b0;
        e_rst = 1'b0;
        hs_prev = 1'b0;
        if (rst) begin
            q.delete();
            e_busy = 1'b0;
            stop_req = 1'b0;
            e_rst = 1'b1;
        end else if (e_busy) begin
            if (CONT && stop) stop_req = 1'b1;
            if (vld && rdy && q.size() > 0) begin
                got.push_back('{res_ch, res_per, res_to});
                void'(q.pop_front());
                hs_prev = 1'b1;
                if (CONT ? stop_req : q.size() == 0) begin
                    e_done = 1'b1;
                    e_busy = 1'b0;
                    stop_req = 1'b0;
                    q.delete();
                end else if (q.size() == 0) fill();
            end
        end else if (start) begin
            m_mask = mask;
            if (mask == 0) e_done = 1'b1;
            else begin
                e_busy = 1'b1;
                fill();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int c = 0; c < CH_NUM; c++) begin
            if (dead[c] != 0) pulse[c] = dead[c] == 2;
            else begin
                ph[c] = (ph[c] + 1) % per[c];
                pulse[c] = ph[c] < hi[c];
            end
        end
        if (rnd) begin
            rdy = $urandom_range(0, 3) != 0;
            mask = CH_NUM'($urandom);
            start = e_busy && $urandom_range(0, 7) == 0;
        end
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (e_busy && n < lim) begin
            step();
            n++;
        end
        if (n >= lim) begin
            chk("scan_timeout", e_busy, 0);
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
        step();
        step();
    endtask

    task automatic scan(input logic [CH_NUM-1:0] m);
        mask = m;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(6000);
    endtask

    task automatic cfg(input int c, input int p, input int h, input int d);
        per[c] = p;
        hi[c] = h;
        dead[c] = d;
    endtask

    task automatic chk_res(input string nm, input int idx, input int ch, input int p, input int to);
        if (idx < got.size()) begin
            chk({nm, "_ch"}, got[idx].ch, ch);
            chk({nm, "_per"}, got[idx].per, p);
            chk({nm, "_to"}, got[idx].to, to);
        end else chk({nm, "_missing"}, got.size(), idx + 1);
    endtask

    initial begin
        int n0, d0, w;
        for (int c = 0; c < CH_NUM; c++) begin
            cfg(c, 8, 4, 0);
            ph[c] = c;
        end
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single channel, period 10 (high 3, low 7).
        cfg(1, 10, 3, 0);
        n0 = got.size(); d0 = dones;
        scan(4'b0010);
        chk("t1_count", got.size() - n0, 1);
        chk_res("t1", n0, 1, 10, 0);
        chk("t1_dones", dones - d0, 1);

        // Two channels in ascending order.
        cfg(0, 8, 4, 0);
        cfg(2, 21, 10, 0);
        n0 = got.size(); d0 = dones;
        scan(4'b0101);
        chk("t2_count", got.size() - n0, 2);
        chk_res("t2a", n0, 0, 8, 0);
        chk_res("t2b", n0 + 1, 2, 21, 0);
        chk("t2_dones", dones - d0, 1);

        // Stuck-low channel times out in ARM.
        cfg(3, 8, 4, 1);
        n0 = got.size();
        scan(4'b1000);
        chk_res("t3", n0, 3, 16'hFFFF, 1);

        // Long backpressure holds the result.
        cfg(0, 12, 5, 0);
        n0 = got.size(); d0 = dones;
        rdy = 1'b0;
        mask = 4'b0001;
        start = 1'b1;
        step();
        start = 1'b0;
        w = 0;
        while (!vld && w < 500) begin
            step();
            w++;
        end
        chk("t4_vld_seen", vld, 1);
        repeat (50) step();
        chk("t4_no_early", got.size() - n0, 0);
        rdy = 1'b1;
        wait_idle(200);
        chk("t4_count", got.size() - n0, 1);
        chk_res("t4", n0, 0, 12, 0);
        chk("t4_dones", dones - d0, 1);

        // Reset mid-measurement, then an empty-mask start.
        n0 = got.size(); d0 = dones;
        mask = 4'b0001;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (25) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        scan(4'b0000);
        chk("t5_count", got.size() - n0, 0);
        chk("t5_dones", dones - d0, 1);

        // Randomized scans with random backpressure, mask churn and ignored starts.
        for (int s = 0; s < 25; s++) begin
            for (int c = 0; c < CH_NUM; c++) begin
                per[c] = $urandom_range(2, 40);
                cfg(c, per[c], $urandom_range(1, per[c] - 1), ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0);
            end
            rnd = 1'b1;
            scan(CH_NUM'($urandom));
            rnd = 1'b0;
            rdy = 1'b1;
            start = 1'b0;
            step();
        end

`ifdef PMS_CONT_SCAN_EN
        // Continuous scan wraps until stopped; stop during ch1 ends after its result.
        cfg(0, 6, 3, 0);
        cfg(1, 9, 4, 0);
        n0 = got.size(); d0 = dones;
        mask = 4'b0011;
        start = 1'b1;
        step();
        start = 1'b0;
        w = 0;
        while (got.size() - n0 < 3 && w < 3000) begin
            step();
            w++;
        end
        chk("t6_dones_mid", dones - d0, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(1000);
        chk("t6_count", got.size() - n0, 4);
        chk_res("t6a", n0, 0, 6, 0);
        chk_res("t6b", n0 + 1, 1, 9, 0);
        chk_res("t6c", n0 + 2, 0, 6, 0);
        chk_res("t6d", n0 + 3, 1, 9, 0);
        chk("t6_dones", dones - d0, 1);
`endif

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
